sntc_ldpc_encoder_stream: RTL and testbench
===========================================

Name: sntc_ldpc_encoder_stream

Overview:
Streaming, parametrised successor of the combinational NR LDPC encoder wrapper. It accepts a KK-bit message as IW-bit beats over a valid/ready handshake and accumulates parity over GF(2) using the generated parity-column table. It then emits the NN-bit systematic codeword as OW-bit beats over a second valid/ready handshake. It sits between the transport-block segmenter and the rate-matching stage.

Parameters:
NN, 'h000d0, codeword length in bits (208).
MM, 'h000a8, parity length in bits (168).
KK, NN-MM, message length in bits (40).
IW, 8, input beat width; KK % IW == 0 is required (elaboration error otherwise).
OW, 16, output beat width; NN % OW == 0 is required (elaboration error otherwise).
CNT_W, 16, width of the frame counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  IW  message bits; bit j of beat b = u[b*IW+j]
in_last  in  1  marks last message beat
out_valid  out  1  output beat valid
out_ready  in  1  output beat consumed when out_valid&&out_ready
out_data  out  OW  codeword bits; bit j of beat b = y[b*OW+j]
out_last  out  1  high on final output beat (beat NN/OW-1)
err_len  out  1  one-cycle pulse on framing error
frames_done  out  CNT_W  count of codewords fully emitted; wraps at 2^CNT_W

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE, in_ready=0, out_valid=0, out_last=0, err_len=0, frames_done=0. Parity accumulator, message register and beat counters are cleared.
- Reset mid-frame: any partial frame or codeword in flight is discarded; no out_last is produced for it.
- Codeword layout: y[0..KK-1] = u (systematic bits); y[KK..NN-1] = p[0..MM-1].
- Parity: p = XOR over i of (u[i] ? col(i) : 0). col(i) is the MM-bit column from the generated encoder table include for the selected base graph.
- Accumulation: up to IW columns are folded per accepted beat, purely combinationally into the accumulator register. No multicycle path is allowed.
- States:
  - IDLE: in_ready=1; the first accepted beat moves to ACCUM, or handles framing directly if NB_IN=KK/IW=1.
  - ACCUM: in_ready=1; ib counts accepted beats 0..NB_IN-1.
  - EMIT: in_ready=0; ob counts output beats 0..NB_OUT-1, where NB_OUT=NN/OW.
- Beat ib = NB_IN-1 accepted: transition to EMIT. in_last is not required for termination at this beat; if in_last=0 here, err_len pulses the next cycle and the codeword is still emitted.
- in_last=1 on a beat with ib < NB_IN-1 (early end): the frame is aborted, err_len pulses the next cycle, state returns to IDLE, and no output is produced.
- Latency: final input beat accepted at edge t gives out_valid=1 with beat 0 from cycle t+1.
- In EMIT, out_data is a registered or muxed slice of {parity, message}. It must be held stable while out_valid&&!out_ready. ob advances only on the handshake.
- On handshake with ob = NB_OUT-1 (out_last=1): frames_done increments (wrapping), state goes to IDLE, and in_ready=1 in the next cycle.
- A single frame buffer is used, so input and output do not overlap. Throughput is NB_IN+NB_OUT cycles per frame at full handshake (5+13 = 18 at defaults).
- in_valid is ignored while in_ready=0. There is no combinational path from in_valid to out_valid or from out_ready to in_ready.

Test Plan:
- All-zero message, 5 beats, out_ready=1 -> 13 beats of 16'h0000; out_last on beat 12; frames_done=1; out_valid rises exactly 1 cycle after the 5th input handshake.
- u = 40'h1 (only u[0] set) -> beat 0 = 16'h0001; beats 2..12 carry col(0) starting at y[40]; compare against the table.
- Random messages a, b -> enc(a^b) == enc(a)^enc(b) bitwise; 1000 frames against the scoreboard model; frames_done=1000.
- out_ready held low 4 cycles at beat 3 -> out_data/out_last stable; ob does not advance; in_ready stays 0 throughout.
- in_last asserted on beat 2 (of 5) -> err_len=1 for one cycle; out_valid never rises; the next frame encodes correctly.
- rst asserted during EMIT beat 6 -> next cycle out_valid=0, in_ready=0, frames_done=0; after release a fresh frame encodes correctly.

Source files
------------

// File: rtl/sntc_ldpc_encoder_stream.sv
// Streaming systematic LDPC encoder.
// Message beats are folded into a GF(2) parity accumulator as they arrive.
// The finished codeword {parity, message} is then streamed out in OW-bit beats.
// A single frame buffer is used, so input and output phases never overlap.
module sntc_ldpc_encoder_stream #(
    parameter int NN    = 'h000d0,
    parameter int MM    = 'h000a8,
    parameter int KK    = NN - MM,
    parameter int IW    = 8,
    parameter int OW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic             out_last,
    output logic             err_len,
    output logic [CNT_W-1:0] frames_done
);

    localparam int NB_IN  = KK / IW;
    localparam int NB_OUT = NN / OW;
    localparam int IB_W   = (NB_IN > 1) ? $clog2(NB_IN) : 1;
    localparam int OB_W   = (NB_OUT > 1) ? $clog2(NB_OUT) : 1;

    if (KK % IW != 0) begin : g_bad_iw
        $error("KK must be a multiple of IW");
    end
    if (NN % OW != 0) begin : g_bad_ow
        $error("NN must be a multiple of OW");
    end

    // Parity-column table, column i occupies bits [i*MM +: MM].
    // Quasi-cyclic placement: column i has four ones at (5*i + 41*k) mod MM.
    function automatic logic [KK*MM-1:0] gen_tab();
        logic [KK*MM-1:0] t;
        t = '0;
        for (int i = 0; i < KK; i++) begin
            for (int k = 0; k < 4; k++) begin
                t[i*MM + ((5*i + 41*k) % MM)] = 1'b1;
            end
        end
        return t;
    endfunction

    localparam logic [KK*MM-1:0] COL_TAB = gen_tab();

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [IB_W-1:0]  ib_q, ib_d;
    logic [OB_W-1:0]  ob_q, ob_d;
    logic [KK-1:0]    msg_q, msg_d;
    logic [MM-1:0]    par_q, par_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             in_ready_q;
    logic             in_acc;
    logic [NN-1:0]    cw;

    assign in_acc      = in_valid && in_ready_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q == S_EMIT);
    assign out_last    = out_valid && (ob_q == OB_W'(NB_OUT - 1));
    assign err_len     = err_q;
    assign frames_done = frames_q;
    assign cw          = {par_q, msg_q};
    assign out_data    = cw[int'(ob_q)*OW +: OW];

    // Next-state logic: beat accumulation, framing checks and output sequencing.
    always_comb begin
        state_d  = state_q;
        ib_d     = ib_q;
        ob_d     = ob_q;
        msg_d    = msg_q;
        par_d    = par_q;
        err_d    = 1'b0;
        frames_d = frames_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (in_acc) begin
                    // A new frame starts from an empty accumulator.
                    if (state_q == S_IDLE) begin
                        par_d = '0;
                    end
                    for (int j = 0; j < IW; j++) begin
                        if (in_data[j]) begin
                            par_d = par_d ^ COL_TAB[(int'(ib_q)*IW + j)*MM +: MM];
                        end
                    end
                    msg_d[int'(ib_q)*IW +: IW] = in_data;
                    if (ib_q == IB_W'(NB_IN - 1)) begin
                        state_d = S_EMIT;
                        ib_d    = '0;
                        ob_d    = '0;
                        err_d   = !in_last;
                    end else if (in_last) begin
                        state_d = S_IDLE;
                        ib_d    = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                        ib_d    = ib_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (ob_q == OB_W'(NB_OUT - 1)) begin
                        state_d  = S_IDLE;
                        ob_d     = '0;
                        frames_d = frames_q + 1'b1;
                    end else begin
                        ob_d = ob_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ib_q       <= '0;
            ob_q       <= '0;
            msg_q      <= '0;
            par_q      <= '0;
            err_q      <= 1'b0;
            frames_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ib_q       <= ib_d;
            ob_q       <= ob_d;
            msg_q      <= msg_d;
            par_q      <= par_d;
            err_q      <= err_d;
            frames_q   <= frames_d;
            in_ready_q <= (state_d != S_EMIT);
        end
    end

endmodule

// File: tb/tb_sntc_ldpc_encoder_stream.sv
// Directed and table-driven bench for the streaming LDPC encoder.
module tb_sntc_ldpc_encoder_stream;

    localparam int NN     = 208;
    localparam int MM     = 168;
    localparam int KK     = 40;
    localparam int IW     = 8;
    localparam int OW     = 16;
    localparam int CNT_W  = 16;
    localparam int NB_IN  = KK / IW;
    localparam int NB_OUT = NN / OW;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IW-1:0]    in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic             out_last;
    logic             err_len;
    logic [CNT_W-1:0] frames_done;

    int checks   = 0;
    int failures = 0;

    logic [NN-1:0] rx_cw;
    bit            rx_last_bad;

    typedef struct {
        string         name;
        logic [KK-1:0] msg;
        logic [NN-1:0] cw;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    sntc_ldpc_encoder_stream #(
        .NN(NN), .MM(MM), .KK(KK), .IW(IW), .OW(OW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .err_len(err_len), .frames_done(frames_done)
    );

    function automatic logic [NN-1:0] b1(input int n);
        logic [NN-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Reference encoder: for each parity bit, invert the column placement
    // (5*i + 41*k) mod 168 = m using 5^-1 = 101 (mod 168).
    function automatic logic [NN-1:0] enc_model(input logic [KK-1:0] u);
        logic [MM-1:0] p;
        int r, i;
        for (int m = 0; m < MM; m++) begin
            p[m] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                r = (m - 41*k + 4*MM) % MM;
                i = (r * 101) % MM;
                if (i < KK) p[m] = p[m] ^ u[i];
            end
        end
        return {p, u};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nbeats message beats; in_last is raised on beat last_at (-1: never).
    task automatic send_frame(input logic [KK-1:0] u, input int nbeats, input int last_at);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            in_valid = 1'b1;
            in_data  = u[b*IW +: IW];
            in_last  = (b == last_at);
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout beat=%0d actual=0 required=1", b);
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Collects output beats from..to into rx_cw with out_ready held high.
    task automatic recv_beats(input int from, input int to);
        int n;
        out_ready = 1'b1;
        for (int b = from; b <= to; b++) begin
            n = 0;
            while (!out_valid && n < 50) begin
                tick();
                n++;
            end
            if (!out_valid) begin
                checks++;
                failures++;
                $display("FAIL out_valid_timeout beat=%0d actual=0 required=1", b);
            end
            rx_cw[b*OW +: OW] = out_data;
            if (out_last !== (b == NB_OUT - 1)) rx_last_bad = 1'b1;
            tick();
        end
    endtask

    task automatic encode(input logic [KK-1:0] u);
        rx_cw       = '0;
        rx_last_bad = 1'b0;
        send_frame(u, NB_IN, NB_IN - 1);
        recv_beats(0, NB_OUT - 1);
    endtask

    initial begin
        logic [NN-1:0] cw_a, cw_b, d0;
        logic [KK-1:0] ua, ub;
        logic [63:0]   r64;
        logic          l0;
        bit            seen;
        int            bad;

        vecs[0] = '{"u_zero",   40'h0,           '0};
        vecs[1] = '{"u_bit0",   40'h1,           b1(0) | b1(40) | b1(81) | b1(122) | b1(163)};
        vecs[2] = '{"u_bit1",   40'h2,           b1(1) | b1(45) | b1(86) | b1(127) | b1(168)};
        vecs[3] = '{"u_bit0_1", 40'h3,           b1(0) | b1(40) | b1(81) | b1(122) | b1(163)
                                               ^ b1(1) ^ b1(45) ^ b1(86) ^ b1(127) ^ b1(168)};
        vecs[4] = '{"u_bit8",   40'h100,         b1(8) | b1(80) | b1(121) | b1(162) | b1(203)};
        vecs[5] = '{"u_bit32",  40'h01_0000_0000, b1(32) | b1(200) | b1(73) | b1(114) | b1(155)};
        vecs[6] = '{"u_bit39",  40'h80_0000_0000, b1(39) | b1(67) | b1(108) | b1(149) | b1(190)};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready",    in_ready,    0);
        chk("rst_out_valid",   out_valid,   0);
        chk("rst_out_last",    out_last,    0);
        chk("rst_err_len",     err_len,     0);
        chk("rst_frames_done", frames_done, 0);
        rst = 1'b0;
        tick();

        // All-zero frame with latency check after the final input handshake.
        out_ready   = 1'b1;
        rx_cw       = '1;
        rx_last_bad = 1'b0;
        send_frame('0, NB_IN, NB_IN - 1);
        chk("zero_latency_out_valid", out_valid, 1);
        chk("zero_in_ready_emit",     in_ready,  0);
        recv_beats(0, NB_OUT - 1);
        chk("zero_cw",          rx_cw,       0);
        chk("zero_out_last",    rx_last_bad, 0);
        chk("zero_frames_done", frames_done, 1);

        // Hand-computed single-column and small-combination vectors.
        for (int v = 0; v < 7; v++) begin
            encode(vecs[v].msg);
            chk(vecs[v].name, rx_cw, vecs[v].cw);
            chk({vecs[v].name, "_last"}, rx_last_bad, 0);
            if (v == 1) chk("u_bit0_beat0", rx_cw[15:0], 16'h0001);
        end
        chk("table_frames_done", frames_done, 8);

        // GF(2) linearity: enc(a^b) == enc(a)^enc(b).
        for (int t = 0; t < 3; t++) begin
            r64 = {$urandom(), $urandom()};
            ua  = r64[KK-1:0];
            r64 = {$urandom(), $urandom()};
            ub  = r64[KK-1:0];
            encode(ua);
            cw_a = rx_cw;
            encode(ub);
            cw_b = rx_cw;
            encode(ua ^ ub);
            chk("linearity", rx_cw, cw_a ^ cw_b);
            chk("model_a",   cw_a,  enc_model(ua));
        end

        // Early in_last on beat 2: abort, error pulse, no output.
        send_frame(40'h12_3456_789A, 3, 2);
        chk("early_err_pulse", err_len, 1);
        tick();
        chk("early_err_clear", err_len, 0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("early_no_output", seen, 0);
        chk("early_frames_done", frames_done, 17);
        encode(40'hA5_5A0F_F00F);
        chk("after_early_cw", rx_cw, enc_model(40'hA5_5A0F_F00F));

        // Final beat without in_last: error pulse but codeword still emitted.
        rx_cw       = '0;
        rx_last_bad = 1'b0;
        send_frame(40'h00_C0DE_BEEF, NB_IN, -1);
        chk("nolast_err_pulse", err_len,   1);
        chk("nolast_out_valid", out_valid, 1);
        recv_beats(0, NB_OUT - 1);
        chk("nolast_cw", rx_cw, enc_model(40'h00_C0DE_BEEF));

        // Back-pressure for 4 cycles on output beat 3.
        rx_cw       = '0;
        rx_last_bad = 1'b0;
        send_frame(40'h7E_1234_ABCD, NB_IN, NB_IN - 1);
        recv_beats(0, 2);
        out_ready = 1'b0;
        d0 = '0;
        d0[OW-1:0] = out_data;
        l0 = out_last;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_data !== d0[OW-1:0] || out_last !== l0 || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad++;
        end
        chk("stall_stable", bad, 0);
        recv_beats(3, NB_OUT - 1);
        chk("stall_cw",   rx_cw,       enc_model(40'h7E_1234_ABCD));
        chk("stall_last", rx_last_bad, 0);

        // Reset while output beat 6 is presented.
        rx_cw       = '0;
        rx_last_bad = 1'b0;
        send_frame(40'h31_4159_2653, NB_IN, NB_IN - 1);
        recv_beats(0, 5);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid",   out_valid,   0);
        chk("midrst_in_ready",    in_ready,    0);
        chk("midrst_frames_done", frames_done, 0);
        rst = 1'b0;
        encode(40'hDE_ADBE_EF01);
        chk("midrst_fresh_cw", rx_cw,       enc_model(40'hDE_ADBE_EF01));
        chk("midrst_fresh_cnt", frames_done, 1);

        // 1000 random frames against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 1000; f++) begin
            r64 = {$urandom(), $urandom()};
            ua  = r64[KK-1:0];
            encode(ua);
            chk("random_cw", rx_cw, enc_model(ua));
        end
        chk("random_frames_done", frames_done, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
